pbs_turn_ctrl: RTL and testbench

Turn sequencer for the Pokémon battle datapath. It latches the player's move, then drives the datapath's `target`, `actr`, `calc_dmg` and `app_dmg` strobes through a fixed player-then-AI turn order. After each attack it checks the HP values returned by the datapath and declares a winner when one side reaches 0. It sits between the board I/O (move switches, confirm button) and the datapath, and is the only driver of the datapath control inputs.

---
 rtl/pbs_turn_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pbs_turn_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbs_turn_ctrl.sv
// Turn sequencer for the Pokemon battle datapath: player-then-AI attack order, KO detection.
// Optional selection timeout is compiled in with `define PBS_TURN_TIMEOUT_EN.
module pbs_turn_ctrl #(
    parameter int CALC_CYC    = 3,
    parameter int APPLY_CYC   = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] move_sel,
    input  logic       confirm,
    input  logic [3:0] p_hp,
    input  logic [3:0] AI_hp,
    output logic [1:0] p_move,
    output logic       target,
    output logic       actr,
    output logic       calc_dmg,
    output logic       app_dmg,
    output logic       busy,
    output logic       game_over,
    output logic       winner,
    output logic [7:0] turn_count,
    output logic       timed_out
);

    typedef enum logic [3:0] {
        IDLE, P_SELECT, P_CALC, P_APPLY, P_CHECK,
        AI_CALC, AI_APPLY, AI_CHECK, GAME_OVER
    } state_t;

    localparam int MAX_CYC = (CALC_CYC > APPLY_CYC) ? CALC_CYC : APPLY_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CALC_LOAD  = CNT_W'(CALC_CYC - 1);
    localparam logic [CNT_W-1:0] APPLY_LOAD = CNT_W'(APPLY_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             armed, armed_nxt;
    logic             confirm_q;
    logic [1:0]       p_move_nxt;
    logic             target_nxt, actr_nxt, winner_nxt, timed_out_nxt;
    logic [7:0]       turn_count_nxt;
    logic             timeout_hit;

`ifdef PBS_TURN_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Counts cycles spent in P_SELECT; reads 0 on the first cycle after entry.
    always_ff @(posedge clk) begin
        if (!rst || state != P_SELECT) tmo_cnt <= '0;
        else                           tmo_cnt <= tmo_cnt + 16'd1;
    end

    assign timeout_hit = (state == P_SELECT) && (tmo_cnt == 16'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo;
    assign unused_tmo  = ^TIMEOUT_CYC;
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = (cnt != '0) ? cnt - 1'b1 : cnt;
        armed_nxt      = armed;
        p_move_nxt     = p_move;
        target_nxt     = target;
        actr_nxt       = actr;
        winner_nxt     = winner;
        turn_count_nxt = turn_count;
        timed_out_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (p_hp == 4'd0 || AI_hp == 4'd0) begin
                        state_nxt  = GAME_OVER;
                        winner_nxt = (p_hp == 4'd0);
                    end else begin
                        state_nxt = P_SELECT;
                    end
                end
            end
            P_SELECT: begin
                if (!confirm_q) armed_nxt = 1'b1;
                // An accepted confirm beats a timeout landing in the same cycle.
                if (armed && confirm_q) begin
                    p_move_nxt = move_sel;
                    armed_nxt  = 1'b0;
                    state_nxt  = P_CALC;
                end else if (timeout_hit) begin
                    p_move_nxt    = 2'b00;
                    timed_out_nxt = 1'b1;
                    state_nxt     = P_CALC;
                end
            end
            P_CALC:   if (cnt == '0) state_nxt = P_APPLY;
            P_APPLY:  if (cnt == '0) state_nxt = P_CHECK;
            P_CHECK: begin
                if (AI_hp == 4'd0) begin
                    state_nxt  = GAME_OVER;
                    winner_nxt = 1'b0;
                end else begin
                    state_nxt = AI_CALC;
                end
            end
            AI_CALC:  if (cnt == '0) state_nxt = AI_APPLY;
            AI_APPLY: if (cnt == '0) state_nxt = AI_CHECK;
            AI_CHECK: begin
                if (p_hp == 4'd0) begin
                    state_nxt  = GAME_OVER;
                    winner_nxt = 1'b1;
                end else begin
                    state_nxt = P_SELECT;
                    if (turn_count != 8'hFF) turn_count_nxt = turn_count + 8'd1;
                end
            end
            GAME_OVER: state_nxt = GAME_OVER;
            default:   state_nxt = IDLE;
        endcase

        // Entry actions: reload the phase counter and switch roles only when a phase begins.
        if (state_nxt != state) begin
            case (state_nxt)
                P_CALC:   begin cnt_nxt = CALC_LOAD;  target_nxt = 1'b1; actr_nxt = 1'b0; end
                AI_CALC:  begin cnt_nxt = CALC_LOAD;  target_nxt = 1'b0; actr_nxt = 1'b1; end
                P_APPLY,
                AI_APPLY: cnt_nxt = APPLY_LOAD;
                default:  cnt_nxt = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            armed      <= 1'b0;
            confirm_q  <= 1'b0;
            p_move     <= 2'b00;
            target     <= 1'b0;
            actr       <= 1'b0;
            calc_dmg   <= 1'b0;
            app_dmg    <= 1'b0;
            busy       <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 1'b0;
            turn_count <= 8'd0;
            timed_out  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            armed      <= armed_nxt;
            confirm_q  <= confirm;
            p_move     <= p_move_nxt;
            target     <= target_nxt;
            actr       <= actr_nxt;
            calc_dmg   <= (state_nxt == P_CALC)  || (state_nxt == AI_CALC);
            app_dmg    <= (state_nxt == P_APPLY) || (state_nxt == AI_APPLY);
            busy       <= !(state_nxt inside {IDLE, P_SELECT, GAME_OVER});
            game_over  <= (state_nxt == GAME_OVER);
            winner     <= winner_nxt;
            turn_count <= turn_count_nxt;
            timed_out  <= timed_out_nxt;
        end
    end

endmodule

// File: tb/tb_pbs_turn_ctrl.sv
// Directed self-checking bench for pbs_turn_ctrl (default parameters; timeout test when
// PBS_TURN_TIMEOUT_EN is defined, with TIMEOUT_CYC=20).
module tb_pbs_turn_ctrl;

`ifdef PBS_TURN_TIMEOUT_EN
    localparam int TB_TMO = 20;
`else
    localparam int TB_TMO = 1000;
`endif

    logic       clk = 1'b0;
    logic       rst, start, confirm;
    logic [1:0] move_sel;
    logic [3:0] p_hp, AI_hp;
    logic [1:0] p_move;
    logic       target, actr, calc_dmg, app_dmg, busy, game_over, winner, timed_out;
    logic [7:0] turn_count;

    int checks = 0;
    int errors = 0;

    // Expected {calc_dmg, app_dmg, target, actr, busy} for the 13 cycles after confirm acceptance.
    logic [4:0] exp_seq [0:12] = '{
        5'b10101, 5'b10101, 5'b10101, 5'b01101, 5'b01101, 5'b00101,
        5'b10011, 5'b10011, 5'b10011, 5'b01011, 5'b01011, 5'b00011, 5'b00010
    };

    pbs_turn_ctrl #(.CALC_CYC(3), .APPLY_CYC(2), .TIMEOUT_CYC(TB_TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .move_sel(move_sel), .confirm(confirm),
        .p_hp(p_hp), .AI_hp(AI_hp), .p_move(p_move), .target(target), .actr(actr),
        .calc_dmg(calc_dmg), .app_dmg(app_dmg), .busy(busy), .game_over(game_over),
        .winner(winner), .turn_count(turn_count), .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; confirm = 1'b0; move_sel = 2'b00;
        p_hp = 4'd10; AI_hp = 4'd10;
        step(2);
        rst = 1'b1;
    endtask

    task automatic begin_battle();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Confirms mv from P_SELECT and walks one full turn, ending back in P_SELECT.
    task automatic run_turn(input logic [1:0] mv, input logic [7:0] exp_tc,
                            input bit verbose, input bit hold);
        logic [4:0] obs;
        move_sel = mv;
        confirm  = 1'b1;
        step(1);
        if (verbose) begin
            checks++;
            if (calc_dmg !== 1'b0) begin
                errors++; $display("FAIL confirm_latency calc_dmg=%0b want 0", calc_dmg);
            end
        end
        if (!hold) confirm = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step(1);
            if (verbose) begin
                obs = {calc_dmg, app_dmg, target, actr, busy};
                checks++;
                if (obs !== exp_seq[i]) begin
                    errors++;
                    $display("FAIL turn_cycle%0d {calc,app,tgt,actr,busy}=%b want %b", i + 1, obs, exp_seq[i]);
                end
                if (i == 0) begin
                    checks++;
                    if (p_move !== mv) begin
                        errors++; $display("FAIL p_move_latch got %0d want %0d", p_move, mv);
                    end
                end
                if (i == 11) begin
                    checks++;
                    if (turn_count !== exp_tc - 8'd1) begin
                        errors++; $display("FAIL turn_count_pre got %0d want %0d", turn_count, exp_tc - 8'd1);
                    end
                end
                if (i == 12) begin
                    checks++;
                    if (turn_count !== exp_tc) begin
                        errors++; $display("FAIL turn_count_post got %0d want %0d", turn_count, exp_tc);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; confirm = 1'b0; move_sel = 2'b00;
        p_hp = 4'd10; AI_hp = 4'd10;
        step(2);
        checks++;
        if ({p_move, target, actr, calc_dmg, app_dmg, busy, game_over, winner, turn_count, timed_out} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want all zero",
                     {p_move, target, actr, calc_dmg, app_dmg, busy, game_over, winner, turn_count, timed_out});
        end
        rst = 1'b1;
        step(3);
        checks++;
        if (busy !== 1'b0 || game_over !== 1'b0) begin
            errors++; $display("FAIL idle_hold busy=%0b game_over=%0b want 0 0", busy, game_over);
        end
    endtask

    task automatic test_first_turns();
        do_reset();
        begin_battle();
        checks++;
        if (busy !== 1'b0 || calc_dmg !== 1'b0) begin
            errors++; $display("FAIL p_select_entry busy=%0b calc=%0b want 0 0", busy, calc_dmg);
        end
        run_turn(2'b10, 8'd1, 1'b1, 1'b0);
        run_turn(2'b01, 8'd2, 1'b1, 1'b0);
    endtask

    task automatic test_player_ko();
        do_reset();
        begin_battle();
        move_sel = 2'b01;
        confirm  = 1'b1;
        step(1);
        confirm = 1'b0;
        step(4);                      // cycle 4: P_APPLY
        AI_hp = 4'd0;
        step(2);                      // cycle 6: P_CHECK
        checks++;
        if (game_over !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL pko_check game_over=%0b busy=%0b want 0 1", game_over, busy);
        end
        step(1);
        checks++;
        if ({game_over, winner, busy, calc_dmg, app_dmg} !== 5'b10000) begin
            errors++; $display("FAIL pko_over {go,win,busy,calc,app}=%b want 10000",
                               {game_over, winner, busy, calc_dmg, app_dmg});
        end
        step(3);
        checks++;
        if (actr !== 1'b0 || calc_dmg !== 1'b0) begin
            errors++; $display("FAIL pko_no_ai_phase actr=%0b calc=%0b want 0 0", actr, calc_dmg);
        end
        start = 1'b1;
        step(3);
        start = 1'b0;
        checks++;
        if (game_over !== 1'b1 || busy !== 1'b0 || winner !== 1'b0) begin
            errors++; $display("FAIL pko_start_ignored go=%0b busy=%0b win=%0b want 1 0 0", game_over, busy, winner);
        end
    endtask

    task automatic test_ai_ko();
        do_reset();
        begin_battle();
        run_turn(2'b00, 8'd1, 1'b0, 1'b0);
        move_sel = 2'b11;
        confirm  = 1'b1;
        step(1);
        confirm = 1'b0;
        step(10);                     // cycle 10: AI_APPLY
        p_hp = 4'd0;
        step(3);                      // through AI_CHECK into GAME_OVER
        checks++;
        if ({game_over, winner, busy} !== 3'b110 || turn_count !== 8'd1) begin
            errors++; $display("FAIL aiko {go,win,busy}=%b turn=%0d want 110 1",
                               {game_over, winner, busy}, turn_count);
        end
    endtask

    task automatic test_confirm_held();
        do_reset();
        begin_battle();
        run_turn(2'b11, 8'd1, 1'b0, 1'b1);   // confirm stays high afterwards
        step(6);
        checks++;
        if (calc_dmg !== 1'b0 || busy !== 1'b0 || turn_count !== 8'd1) begin
            errors++; $display("FAIL held_stall calc=%0b busy=%0b turn=%0d want 0 0 1", calc_dmg, busy, turn_count);
        end
        confirm = 1'b0;
        step(1);
        checks++;
        if (calc_dmg !== 1'b0) begin
            errors++; $display("FAIL held_release calc=%0b want 0", calc_dmg);
        end
        run_turn(2'b01, 8'd2, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        begin_battle();
        move_sel = 2'b11;
        confirm  = 1'b1;
        step(1);
        confirm = 1'b0;
        step(7);                      // cycle 7: AI_CALC
        checks++;
        if (actr !== 1'b1 || calc_dmg !== 1'b1 || p_move !== 2'b11) begin
            errors++; $display("FAIL mid_pre actr=%0b calc=%0b p_move=%0d want 1 1 3", actr, calc_dmg, p_move);
        end
        rst = 1'b0;
        step(1);
        checks++;
        if ({p_move, target, actr, calc_dmg, app_dmg, busy, game_over, winner, turn_count, timed_out} !== 18'd0) begin
            errors++;
            $display("FAIL mid_reset got %b want all zero",
                     {p_move, target, actr, calc_dmg, app_dmg, busy, game_over, winner, turn_count, timed_out});
        end
        rst = 1'b1;
        step(3);
        checks++;
        if (busy !== 1'b0 || calc_dmg !== 1'b0) begin
            errors++; $display("FAIL mid_idle busy=%0b calc=%0b want 0 0", busy, calc_dmg);
        end
    endtask

    task automatic test_idle_ko();
        do_reset();
        p_hp = 4'd0;
        begin_battle();
        checks++;
        if ({game_over, winner, busy} !== 3'b110) begin
            errors++; $display("FAIL idle_pko {go,win,busy}=%b want 110", {game_over, winner, busy});
        end
        do_reset();
        AI_hp = 4'd0;
        begin_battle();
        checks++;
        if ({game_over, winner, busy} !== 3'b100) begin
            errors++; $display("FAIL idle_aiko {go,win,busy}=%b want 100", {game_over, winner, busy});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        begin_battle();
        for (int t = 0; t < 300; t++) run_turn(t[1:0], 8'd0, 1'b0, 1'b0);
        checks++;
        if (turn_count !== 8'd255) begin
            errors++; $display("FAIL turn_saturate got %0d want 255", turn_count);
        end
    endtask

`ifdef PBS_TURN_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        move_sel = 2'b11;
        begin_battle();
        step(19);
        checks++;
        if (timed_out !== 1'b0 || calc_dmg !== 1'b0) begin
            errors++; $display("FAIL tmo_early timed_out=%0b calc=%0b want 0 0", timed_out, calc_dmg);
        end
        step(1);
        checks++;
        if ({timed_out, calc_dmg, target, p_move} !== 5'b11100) begin
            errors++; $display("FAIL tmo_fire {tmo,calc,tgt,p_move}=%b want 11100",
                               {timed_out, calc_dmg, target, p_move});
        end
        step(1);
        checks++;
        if (timed_out !== 1'b0) begin
            errors++; $display("FAIL tmo_pulse timed_out=%0b want 0", timed_out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_turns();
        test_player_ko();
        test_ai_ko();
        test_confirm_held();
        test_reset_mid();
        test_idle_ko();
        test_saturation();
`ifdef PBS_TURN_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
